// File: rtl/square_wave_synth.sv
// square_wave_synth: N-channel programmable square-wave generator with shared prescaler,
// register-programmable periods, phase-sync restart and registered channel-count mix.
module square_wave_synth #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 12,
    parameter int PRE_W  = 4,
    parameter int CH_W   = $clog2(NUM_CH),
    parameter int MIX_W  = $clog2(NUM_CH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [PRE_W-1:0]  prescale,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_data,
    input  logic              sync,
    output logic [NUM_CH-1:0] wave,
    output logic [MIX_W-1:0]  mix,
    output logic              tick
);
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [CNT_W-1:0]  period_q [NUM_CH];
    logic [CNT_W-1:0]  period_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] wave_q, wave_d;
    logic [MIX_W-1:0]  mix_q, mix_d;
    logic              tick_q, tick_d, tick_now;

    always_comb begin
        tick_now = pre_q == '0;
        pre_d    = (sync || tick_now) ? prescale : pre_q - 1'b1;
        tick_d   = tick_now && !sync;
        mix_d    = '0;
        wave_d   = wave_q;
        for (int i = 0; i < NUM_CH; i++) begin
            mix_d       = mix_d + MIX_W'(wave_q[i]);
            period_d[i] = (wr_en && wr_ch == CH_W'(i)) ? wr_data : period_q[i];
            cnt_d[i]    = cnt_q[i];
            // sync loads the freshly written period; a tick reload still uses the old one
            if (sync) begin
                cnt_d[i]  = period_d[i];
                wave_d[i] = 1'b0;
            end else if (tick_now) begin
                cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - 1'b1 : period_q[i];
                if (cnt_q[i] == '0)
                    wave_d[i] = (period_q[i] != '0) && !wave_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            wave_q <= '0;
            mix_q  <= '0;
            tick_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            pre_q    <= pre_d;
            wave_q   <= wave_d;
            mix_q    <= mix_d;
            tick_q   <= tick_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
        end
    end

    assign wave = wave_q;
    assign mix  = mix_q;
    assign tick = tick_q;
endmodule

// File: tb/tb_square_wave_synth.sv
// tb_square_wave_synth: scenario tests plus randomized lockstep comparison against a
// cycle-level behavioural model of the tone generator.
module tb_square_wave_synth;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 12;
    localparam int PRE_W  = 4;
    localparam int CH_W   = 2;
    localparam int MIX_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [PRE_W-1:0]  prescale = '0;
    logic              wr_en = 1'b0;
    logic [CH_W-1:0]   wr_ch = '0;
    logic [CNT_W-1:0]  wr_data = '0;
    logic              sync = 1'b0;
    logic [NUM_CH-1:0] wave;
    logic [MIX_W-1:0]  mix;
    logic              tick;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int          m_pre;
    int          m_period [NUM_CH];
    int          m_cnt [NUM_CH];
    bit [3:0]    m_wave;
    int          m_mix;
    bit          m_tick;

    square_wave_synth #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
        .clk(clk), .rst_n(rst_n), .prescale(prescale), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_data(wr_data), .sync(sync), .wave(wave), .mix(mix), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pre = 0; m_wave = '0; m_mix = 0; m_tick = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_period[i] = 0;
            m_cnt[i] = 0;
        end
    endtask

    task automatic model_edge();
        int np [NUM_CH];
        bit [3:0] ow;
        bit tk;
        ow = m_wave;
        tk = (m_pre == 0);
        for (int i = 0; i < NUM_CH; i++)
            np[i] = (wr_en && int'(wr_ch) == i) ? int'(wr_data) : m_period[i];
        m_mix  = $countones(ow);
        m_tick = tk && !sync;
        if (sync) begin
            m_pre = int'(prescale);
            for (int i = 0; i < NUM_CH; i++) begin
                m_cnt[i] = np[i];
                m_wave[i] = 1'b0;
            end
        end else begin
            m_pre = tk ? int'(prescale) : m_pre - 1;
            if (tk)
                for (int i = 0; i < NUM_CH; i++)
                    if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
                    else begin
                        m_cnt[i] = m_period[i];
                        m_wave[i] = (m_period[i] != 0) ? !ow[i] : 1'b0;
                    end
        end
        for (int i = 0; i < NUM_CH; i++) m_period[i] = np[i];
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
    endtask

    task automatic write_period(input int ch, input int data);
        wr_en = 1'b1; wr_ch = CH_W'(ch); wr_data = CNT_W'(data);
        step();
        wr_en = 1'b0;
    endtask

    task automatic do_sync();
        sync = 1'b1;
        step();
        sync = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({wave, mix, tick} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got wave=%b mix=%0d tick=%b expected all 0", wave, mix, tick);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            step();
            checks++;
            if (wave !== 4'b0 || mix !== 3'd0 || tick !== 1'b1) begin
                errors++;
                $display("FAIL idle_after_reset cyc %0d: got wave=%b mix=%0d tick=%b expected 0 0 1", k, wave, mix, tick);
            end
        end
    endtask

    task automatic test_basic_tone();
        int edges[$];
        bit pw;
        int t0;
        prescale = 0;
        write_period(0, 3);
        do_sync();
        t0 = cyc;
        pw = wave[0];
        checks++;
        if (wave !== 4'b0) begin
            errors++;
            $display("FAIL sync_clears_wave: got %b expected 0000", wave);
        end
        for (int k = 0; k < 40; k++) begin
            step();
            if (wave[0] !== pw) begin
                edges.push_back(cyc - t0);
                pw = wave[0];
            end
            checks++;
            if (mix !== MIX_W'(m_mix)) begin
                errors++;
                $display("FAIL tone_mix cyc %0d: got %0d expected %0d", k, mix, m_mix);
            end
        end
        checks++;
        if (edges.size() < 8) begin
            errors++;
            $display("FAIL tone_edge_count: got %0d expected >= 8", edges.size());
        end else
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (edges[k] != (k + 1) * 4) begin
                    errors++;
                    $display("FAIL tone_edge_%0d: got %0d expected %0d", k, edges[k], (k + 1) * 4);
                end
            end
    endtask

    task automatic test_prescale();
        int edges[$];
        bit pw;
        int t0;
        prescale = 2;
        write_period(1, 1);
        do_sync();
        t0 = cyc;
        pw = wave[1];
        for (int k = 0; k < 36; k++) begin
            step();
            if (wave[1] !== pw) begin
                edges.push_back(cyc - t0);
                pw = wave[1];
            end
        end
        checks++;
        if (edges.size() != 6) begin
            errors++;
            $display("FAIL pre2_edge_count: got %0d expected 6", edges.size());
        end else
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (edges[k] != (k + 1) * 6) begin
                    errors++;
                    $display("FAIL pre2_edge_%0d: got %0d expected %0d", k, edges[k], (k + 1) * 6);
                end
            end
        edges.delete();
        step();
        prescale = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            checks++;
            if (wave !== m_wave || tick !== m_tick) begin
                errors++;
                $display("FAIL pre_change cyc %0d: got wave=%b tick=%b expected %b %b", k, wave, tick, m_wave, m_tick);
            end
            if (wave[1] !== pw) begin
                edges.push_back(cyc);
                pw = wave[1];
            end
        end
        checks++;
        if (edges.size() < 3 || edges[$] - edges[$-1] != 2) begin
            errors++;
            $display("FAIL pre0_rate: got %0d edges, last gap wrong, expected gap 2", edges.size());
        end
    endtask

    task automatic test_period_change();
        int edges[$];
        int exp_e [4] = '{11, 22, 25, 28};
        bit pw;
        int t0;
        prescale = 0;
        write_period(2, 10);
        do_sync();
        t0 = cyc;
        pw = wave[2];
        for (int k = 0; k < 40; k++) begin
            if (k == 14) begin
                wr_en = 1'b1; wr_ch = 2'd2; wr_data = 12'd2;
            end
            step();
            wr_en = 1'b0;
            if (wave[2] !== pw) begin
                edges.push_back(cyc - t0);
                pw = wave[2];
            end
        end
        checks++;
        if (edges.size() < 4) begin
            errors++;
            $display("FAIL period_change_edges: got %0d expected >= 4", edges.size());
        end else
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (edges[k] != exp_e[k]) begin
                    errors++;
                    $display("FAIL period_change_edge_%0d: got %0d expected %0d", k, edges[k], exp_e[k]);
                end
            end
    endtask

    task automatic test_all_sync();
        int mx = 0;
        prescale = 0;
        for (int c = 0; c < NUM_CH; c++) write_period(c, 5);
        do_sync();
        for (int k = 0; k < 36; k++) begin
            step();
            checks++;
            if ((wave !== 4'b0000 && wave !== 4'b1111) || (mix !== 3'd0 && mix !== 3'd4) || mix !== MIX_W'(m_mix)) begin
                errors++;
                $display("FAIL in_phase cyc %0d: got wave=%b mix=%0d expected aligned, mix=%0d", k, wave, mix, m_mix);
            end
        end
        for (int k = 0; k < 36; k++) begin
            if (k == 0) begin
                wr_en = 1'b1; wr_ch = 2'd3; wr_data = 12'd0;
            end
            step();
            wr_en = 1'b0;
            if (k >= 12 && int'(mix) > mx) mx = int'(mix);
        end
        checks++;
        if (mx != 3 || wave[3] !== 1'b0) begin
            errors++;
            $display("FAIL silence_ch3: got max mix=%0d wave3=%b expected 3 and 0", mx, wave[3]);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 49) == 0) prescale = PRE_W'($urandom_range(0, 3));
            wr_en = ($urandom_range(0, 3) == 0);
            wr_ch = CH_W'($urandom_range(0, 3));
            wr_data = ($urandom_range(0, 15) == 0) ? 12'hfff : CNT_W'($urandom_range(0, 12));
            sync = ($urandom_range(0, 40) == 0);
            step();
            checks++;
            if (wave !== m_wave || mix !== MIX_W'(m_mix) || tick !== m_tick) begin
                errors++;
                $display("FAIL random cyc %0d: got wave=%b mix=%0d tick=%b expected %b %0d %b",
                         k, wave, mix, tick, m_wave, m_mix, m_tick);
            end
        end
        wr_en = 1'b0;
        sync = 1'b0;
    endtask

    task automatic test_async_reset();
        prescale = 0;
        write_period(0, 3);
        write_period(1, 3);
        write_period(2, 0);
        write_period(3, 3);
        do_sync();
        repeat (4) step();
        checks++;
        if (wave !== 4'b1011) begin
            errors++;
            $display("FAIL pre_reset_wave: got %b expected 1011", wave);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({wave, mix, tick} !== '0) begin
            errors++;
            $display("FAIL async_clear: got wave=%b mix=%0d tick=%b expected all 0", wave, mix, tick);
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            step();
            checks++;
            if (wave !== 4'b0 || mix !== 3'd0 || tick !== 1'b1) begin
                errors++;
                $display("FAIL post_reset_silent cyc %0d: got wave=%b mix=%0d tick=%b expected 0 0 1", k, wave, mix, tick);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_tone();
        test_prescale();
        test_period_change();
        test_all_sync();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
